if_id_queue: RTL and testbench
==============================

# if_id_queue

Instruction queue between the fetch stage and the decode stage. It captures each instruction word and its word address as fetch produces them, and buffers them in a small FIFO. It presents the oldest entry to decode through a valid/ready handshake. It back-pressures fetch through a hold request that leaves room for the instructions already in flight, and it discards its whole contents on a pipeline flush (jump or redirect).

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥ 4.
- SLACK, 2, entries kept free for words already in flight in fetch; 1 ≤ SLACK < DEPTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
- flush  input  1  discard all queued entries (jump/redirect).
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_ins  input  32  instruction word from fetch.
- in_pc  input  32  word address of in_ins.
- hold_req  output  1  request fetch to hold its address (drives fetch hold_en).
- out_valid  output  1  head entry is valid for decode.
- out_ins  output  32  head instruction; 32'h0000_0013 (NOP) when out_valid=0.
- out_pc  output  32  head word address; 32'h0 when out_valid=0.
- id_ready  input  1  decode consumes head this cycle when out_valid=1.
- overflow  output  1  sticky: a valid input arrived with no free entry and was dropped.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH × 64-bit register array (ins, pc), read pointer, write pointer, occupancy count.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- rd = out_valid & id_ready & ~flush.
- wr = in_valid & ~flush & (count < DEPTH | rd).
  - A write is accepted when full if a read occurs in the same cycle; count is unchanged.
- Per edge, when rst=1:
  - wr: store {in_ins, in_pc} at wr_ptr and advance wr_ptr.
  - rd: advance rd_ptr.
  - count: +1 for wr only, −1 for rd only, unchanged for both or neither.
- flush=1, which has priority over everything except reset:
  - rd_ptr, wr_ptr and count go to 0.
  - The in_valid and id_ready of that cycle are ignored; nothing is written or read.
  - overflow is unaffected.
- Drop: in_valid=1, ~flush, count=DEPTH, ~rd → the word is discarded, overflow←1, and queue contents are unchanged.
- out_valid = (count ≠ 0). out_ins/out_pc are mem[rd_ptr] when valid, otherwise NOP / 0.
- hold_req = (count ≥ DEPTH − SLACK). It is a function of registered state only.
- Reset (rst=0 at edge):
  - pointers, count and overflow go to 0; array contents go to 0.
  - Resulting outputs: out_valid=0, out_ins=32'h0000_0013, out_pc=0, hold_req=0, overflow=0, count=0.
  - Reset overrides flush and in-flight handshakes.

## Timing
- Write-to-visible latency is 1 cycle: a word accepted at edge N is on out_ins with out_valid=1 after edge N if the queue was empty.
- Outputs have no combinational path from in_valid or in_ins. Paths from id_ready and flush reach only next-state logic.
- Read is show-ahead: the head is valid in the same cycle as out_valid. Consume occurs at the edge where out_valid & id_ready. The next entry appears after that edge.
- Throughput: one write and one read per cycle sustained, at any occupancy.
- hold_req changes only after an edge. With SLACK=2 it covers the two words fetch can emit after hold is seen (address stage plus cache stage), so overflow never sets in normal operation.
- Flush at edge N: after edge N, out_valid=0 and count=0. A word with in_valid at N+1 is accepted normally.
- Reset mid-operation: the state after the reset edge is identical to power-up reset, regardless of occupancy.

## Test plan
- Reset → out_valid=0, out_ins=32'h00000013, out_pc=0, hold_req=0, count=0, overflow=0.
- Fill without reading (DEPTH=4, SLACK=2):
  - Write pc 0..3 with ins 32'hA0..A3, id_ready=0.
  - hold_req rises after the 2nd write; count=4 after the 4th.
  - A 5th in_valid with pc 4 → overflow=1, count stays 4, head still pc 0/ins A0.
- Drain in order: from full, id_ready=1 for 4 cycles → out_pc 0,1,2,3 in order; then out_valid=0 and hold_req falls when count <2.
- Simultaneous read+write when full: count=4, in_valid=1 with pc 7, id_ready=1 → count remains 4, overflow unchanged, pc 7 emerges last. Check pointer wrap across this step.
- Flush with concurrent traffic: count=3, flush=1 with in_valid=1 and id_ready=1 → after the edge count=0, out_valid=0. Next cycle, in_valid with pc 20 → out_pc=20 one cycle later.
- Reset mid-operation: count=3, overflow=1, rst=0 for one edge → all outputs at their reset values, including overflow=0.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: small FIFO of {ins, pc} with show-ahead
// head, fetch hold request with in-flight slack, flush and sticky overflow.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int SLACK = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_ins,
  input  logic [31:0]                in_pc,
  output logic                       hold_req,
  output logic                       out_valid,
  output logic [31:0]                out_ins,
  output logic [31:0]                out_pc,
  input  logic                       id_ready,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic rd, wr, drop;

  always_comb begin
    rd   = (count_q != '0) && id_ready && !flush;
    wr   = in_valid && !flush && ((count_q < CW'(DEPTH)) || rd);
    drop = in_valid && !flush && !wr;

    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr) begin
        mem_d[wr_ptr_q] = {in_ins, in_pc};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // simultaneous read and write leaves occupancy unchanged
      if (wr && !rd) begin
        count_d = count_q + CW'(1);
      end else if (rd && !wr) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // all outputs decode registered state only
  assign out_valid = (count_q != '0);
  assign out_ins   = out_valid ? mem_q[rd_ptr_q][63:32] : NOP;
  assign out_pc    = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
  assign hold_req  = (count_q >= CW'(DEPTH - SLACK));
  assign overflow  = overflow_q;
  assign count     = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: expected {ins, pc} pushed on accepted
// writes, popped and compared whenever decode consumes the head.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int SLACK = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_ins;
  logic [31:0] in_pc;
  logic        hold_req;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        id_ready;
  logic        overflow;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] sb[$];
  logic        ovf_m;
  logic [31:0] last_pc;

  if_id_queue #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ins(in_ins),
    .in_pc(in_pc), .hold_req(hold_req), .out_valid(out_valid), .out_ins(out_ins),
    .out_pc(out_pc), .id_ready(id_ready), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus from a negedge to the next; the model decides
  // acceptance from its own occupancy and checks the head on every consume.
  task automatic drive(input logic fl, input logic iv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic rdy);
    logic rd_m, wr_m;
    logic [63:0] head;
    flush = fl; in_valid = iv; in_ins = ins; in_pc = pc; id_ready = rdy;
    rd_m = (sb.size() != 0) && rdy && !fl;
    wr_m = iv && !fl && ((sb.size() < DEPTH) || rd_m);
    if (rd_m) begin
      head = sb.pop_front();
      last_pc = head[31:0];
      n_cmp++;
      if ({out_valid, out_ins, out_pc} !== {1'b1, head}) begin
        n_bad++;
        $display("FAIL head_pop: got v=%b ins=%h pc=%h want v=1 ins=%h pc=%h",
                 out_valid, out_ins, out_pc, head[63:32], head[31:0]);
      end
    end
    if (iv && !fl && !wr_m) ovf_m = 1'b1;
    if (fl) sb.delete();
    if (wr_m) sb.push_back({ins, pc});
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; id_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; id_ready = 1'b0;
    in_ins = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete(); ovf_m = 1'b0;
    n_cmp++;
    if ({out_valid, out_ins, out_pc, hold_req, count, overflow} !==
        {1'b0, NOP, 32'h0, 1'b0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b ins=%h pc=%h hold=%b cnt=%0d ovf=%b want 0/00000013/0/0/0/0",
               out_valid, out_ins, out_pc, hold_req, count, overflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'hA0 + i, i, 1'b0);
      n_cmp++;
      if (hold_req !== (i >= 1)) begin
        n_bad++;
        $display("FAIL fill_hold[%0d]: got %b want %b", i, hold_req, (i >= 1));
      end
      n_cmp++;
      if (count !== 3'(i + 1)) begin
        n_bad++;
        $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1);
      end
    end
    n_cmp++;
    if ({out_valid, out_ins, out_pc, overflow} !== {1'b1, 32'hA0, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL fill_head: got v=%b ins=%h pc=%h ovf=%b want 1/a0/0/0",
               out_valid, out_ins, out_pc, overflow);
    end
  endtask

  task automatic test_full_rw();
    drive(1'b0, 1'b1, 32'hA7, 32'd7, 1'b1);
    n_cmp++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL full_rw: got cnt=%0d ovf=%b want cnt=4 ovf=0", count, overflow);
    end
    n_cmp++;
    if ({out_ins, out_pc} !== {32'hA1, 32'd1}) begin
      n_bad++;
      $display("FAIL full_rw_head: got ins=%h pc=%h want a1/1", out_ins, out_pc);
    end
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b1, 32'hA4, 32'd4, 1'b0);
    n_cmp++;
    if ({overflow, count, out_ins, out_pc} !== {ovf_m, 3'd4, 32'hA1, 32'd1}) begin
      n_bad++;
      $display("FAIL overflow_drop: got ovf=%b cnt=%0d ins=%h pc=%h want 1/4/a1/1",
               overflow, count, out_ins, out_pc);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      n_cmp++;
      if (hold_req !== (sb.size() >= DEPTH - SLACK)) begin
        n_bad++;
        $display("FAIL drain_hold[%0d]: got %b want %b", i, hold_req,
                 (sb.size() >= DEPTH - SLACK));
      end
    end
    n_cmp++;
    if (last_pc !== 32'd7) begin
      n_bad++;
      $display("FAIL drain_last: got pc=%0d want 7", last_pc);
    end
    n_cmp++;
    if ({out_valid, out_ins, out_pc, count, overflow} !== {1'b0, NOP, 32'h0, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL drain_empty: got v=%b ins=%h pc=%h cnt=%0d ovf=%b want 0/00000013/0/0/1",
               out_valid, out_ins, out_pc, count, overflow);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 32'hB000, 32'd100, 1'b0);
    drive(1'b0, 1'b1, 32'hB001, 32'd101, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 32'hB100 + i, 32'd200 + i, 1'b1);
      n_cmp++;
      if (count !== 3'd2) begin
        n_bad++;
        $display("FAIL b2b_count[%0d]: got %0d want 2", i, count);
      end
    end
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      n_cmp++;
      if ({count, overflow, hold_req} !==
          {3'(sb.size()), ovf_m, (sb.size() >= DEPTH - SLACK)}) begin
        n_bad++;
        $display("FAIL random_state[%0d]: got cnt=%0d ovf=%b hold=%b want cnt=%0d ovf=%b",
                 i, count, overflow, hold_req, sb.size(), ovf_m);
      end
    end
  endtask

  task automatic test_flush();
    while (sb.size() != 0) drive(1'b0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'hC0 + i, 32'd30 + i, 1'b0);
    drive(1'b1, 1'b1, 32'hCC, 32'd99, 1'b1);
    n_cmp++;
    if ({count, out_valid, out_ins, out_pc} !== {3'd0, 1'b0, NOP, 32'h0}) begin
      n_bad++;
      $display("FAIL flush_empty: got cnt=%0d v=%b ins=%h pc=%h want 0/0/00000013/0",
               count, out_valid, out_ins, out_pc);
    end
    drive(1'b0, 1'b1, 32'hD20, 32'd20, 1'b0);
    n_cmp++;
    if ({out_valid, out_ins, out_pc, count} !== {1'b1, 32'hD20, 32'd20, 3'd1}) begin
      n_bad++;
      $display("FAIL flush_refill: got v=%b ins=%h pc=%h cnt=%0d want 1/d20/20/1",
               out_valid, out_ins, out_pc, count);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'hE0 + i, 32'd40 + i, 1'b0);
    drive(1'b0, 1'b1, 32'hEE, 32'd50, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({count, overflow} !== {3'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL midop_pre: got cnt=%0d ovf=%b want 3/1", count, overflow);
    end
    rst = 1'b0; flush = 1'b1; in_valid = 1'b1; id_ready = 1'b1;
    in_ins = 32'hFF; in_pc = 32'd77;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; id_ready = 1'b0;
    sb.delete(); ovf_m = 1'b0;
    n_cmp++;
    if ({out_valid, out_ins, out_pc, hold_req, count, overflow} !==
        {1'b0, NOP, 32'h0, 1'b0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL midop_reset: got v=%b ins=%h pc=%h hold=%b cnt=%0d ovf=%b want 0/00000013/0/0/0/0",
               out_valid, out_ins, out_pc, hold_req, count, overflow);
    end
    drive(1'b0, 1'b1, 32'hF1, 32'd61, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    n_cmp++;
    if (count !== 3'd0) begin
      n_bad++;
      $display("FAIL midop_after: got cnt=%0d want 0", count);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; id_ready = 1'b0;
    in_ins = '0; in_pc = '0; ovf_m = 1'b0; last_pc = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_full_rw();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule
